// File: rtl/div8by4_seq.sv
// Sequential unsigned restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
module div8by4_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    localparam int CNT_W = $clog2(2*WIDTH+1);
    localparam logic [CNT_W-1:0] STEPS = CNT_W'(2*WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        shifted = {rem_q, sr_q[2*WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d   = divisor;
                    state_d = RUN;
                    if (divisor == '0) begin
                        // Zero divisor spends a single RUN cycle with the arithmetic bypassed.
                        sr_d  = '1;
                        rem_d = dividend[WIDTH-1:0];
                        dbz_d = 1'b1;
                        cnt_d = CNT_W'(1);
                    end else begin
                        sr_d  = dividend;
                        rem_d = '0;
                        dbz_d = 1'b0;
                        cnt_d = STEPS;
                    end
                end
            end
            RUN: begin
                if (!dbz_q) begin
                    sr_d  = {sr_q[2*WIDTH-2:0], ~trial[WIDTH]};
                    rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    // in_ready is held low while reset is asserted even though the state is IDLE.
    assign in_ready    = rst_n & (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = sr_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8by4_seq.sv
// Directed and exhaustive checks for div8by4_seq (WIDTH=4).
module tb_div8by4_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int pass_cnt;
    int total_cnt;

    div8by4_seq #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: accepts one operand pair, waits for the result, consumes it.
    task automatic divide(input logic [7:0] a, input logic [3:0] b,
                          output logic [7:0] q, output logic [3:0] r,
                          output logic z, output int lat);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total_cnt++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || quotient !== 8'd0 ||
            remainder !== 4'd0 || div_by_zero !== 1'b0)
            $display("FAIL reset_state: got rdy=%b vld=%b q=%0d r=%0d z=%b, want 0 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [7:0] va[5] = '{8'd200, 8'd255, 8'd225, 8'd0, 8'd9};
        logic [3:0] vb[5] = '{4'd13, 4'd1, 4'd15, 4'd7, 4'd15};
        logic [7:0] eq[5] = '{8'd15, 8'd255, 8'd15, 8'd0, 8'd0};
        logic [3:0] er[5] = '{4'd5, 4'd0, 4'd0, 4'd0, 4'd9};
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            divide(va[i], vb[i], q, r, z, lat);
            total_cnt++;
            if (q !== eq[i] || r !== er[i] || z !== 1'b0)
                $display("FAIL basic_%0d_by_%0d: got q=%0d r=%0d z=%b, want q=%0d r=%0d z=0",
                         va[i], vb[i], q, r, z, eq[i], er[i]);
            else pass_cnt++;
            total_cnt++;
            if (lat != 8)
                $display("FAIL basic_latency_%0d_by_%0d: got %0d cycles, want 8", va[i], vb[i], lat);
            else pass_cnt++;
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
        @(negedge clk);
        divide(8'd100, 4'd0, q, r, z, lat);
        total_cnt++;
        if (q !== 8'd255 || r !== 4'd4 || z !== 1'b1)
            $display("FAIL div_zero_result: got q=%0d r=%0d z=%b, want q=255 r=4 z=1", q, r, z);
        else pass_cnt++;
        total_cnt++;
        if (lat != 1)
            $display("FAIL div_zero_latency: got %0d cycles, want 1", lat);
        else pass_cnt++;
        divide(8'd50, 4'd5, q, r, z, lat);
        total_cnt++;
        if (q !== 8'd10 || r !== 4'd0 || z !== 1'b0 || lat != 8)
            $display("FAIL after_zero_50_by_5: got q=%0d r=%0d z=%b lat=%0d, want q=10 r=0 z=0 lat=8",
                     q, r, z, lat);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd13;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total_cnt++;
        if (lat != 8) $display("FAIL bp_latency: got %0d cycles, want 8", lat);
        else pass_cnt++;
        dividend = 8'd77;
        divisor  = 4'd3;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
            total_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 8'd15 ||
                remainder !== 4'd5 || div_by_zero !== 1'b0)
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b q=%0d r=%0d z=%b, want 1 0 15 5 0",
                         i, out_valid, in_ready, quotient, remainder, div_by_zero);
            else pass_cnt++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        else pass_cnt++;
        // A capture of 77/3 during DONE would have started a run and dropped in_ready.
        @(posedge clk);
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_no_capture: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
        int         seen;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd13;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || quotient !== 8'd0 ||
            remainder !== 4'd0 || div_by_zero !== 1'b0)
            $display("FAIL midrun_reset: got vld=%b rdy=%b q=%0d r=%0d z=%b, want all 0",
                     out_valid, in_ready, quotient, remainder, div_by_zero);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        total_cnt++;
        if (seen != 0 || in_ready !== 1'b1)
            $display("FAIL midrun_no_pulse: got %0d out_valid cycles rdy=%b, want 0 and 1", seen, in_ready);
        else pass_cnt++;
        @(negedge clk);
        divide(8'd60, 4'd7, q, r, z, lat);
        total_cnt++;
        if (q !== 8'd8 || r !== 4'd4 || z !== 1'b0 || lat != 8)
            $display("FAIL midrun_60_by_7: got q=%0d r=%0d z=%b lat=%0d, want q=8 r=4 z=0 lat=8",
                     q, r, z, lat);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
        int         recon;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                divide(8'(a), 4'(b), q, r, z, lat);
                total_cnt++;
                if (b == 0) begin
                    if (q !== 8'hFF || r !== 4'(a % 16) || z !== 1'b1 || lat != 1)
                        $display("FAIL sweep_%0d_by_0: got q=%0d r=%0d z=%b lat=%0d, want q=255 r=%0d z=1 lat=1",
                                 a, q, r, z, lat, a % 16);
                    else pass_cnt++;
                end else begin
                    recon = int'(q) * b + int'(r);
                    if (recon != a || int'(r) >= b || q !== 8'(a / b) || z !== 1'b0 || lat != 8)
                        $display("FAIL sweep_%0d_by_%0d: got q=%0d r=%0d z=%b lat=%0d, want q=%0d r=%0d z=0 lat=8",
                                 a, b, q, r, z, lat, a / b, a % b);
                    else pass_cnt++;
                end
            end
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        rst_n     = 1'b1;
        test_reset();
        test_basic();
        test_div_zero();
        test_backpressure();
        test_reset_mid_run();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
